uart_frame_tx: RTL and testbench

Frame sender on the user side of the UART byte-transmit interface (`send_en` / `data_byte_tx` / `tx_done`). It buffers payload bytes written by a local client. On `start` it emits one frame to the UART transmitter, one byte per handshake: start-of-frame byte, length byte, payload, then an optional checksum. It closes the loop the UART core leaves open: it owns `send_en` and paces itself on `tx_done`.

---
 rtl/uart_frame_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   Frame sender for a UART byte-transmit core. Payload bytes written by a
//   local client are buffered. On start, one frame is handed to the UART
//   transmitter one byte per send_en/tx_done handshake:
//     SOF, N, payload[0..N-1] [, CHK]
//   CHK = N ^ payload[0] ^ ... ^ payload[N-1]. It is appended only when the
//   UART_FRAME_CHKSUM_EN macro is defined.
//
// Parameters
//   DEPTH  payload buffer size in bytes (power of two, 2..128)
//   SOF    start-of-frame byte
//
// Ports
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   wr_en        write wr_data into the payload buffer
//   wr_data      payload byte
//   wr_full      a write now would be dropped (busy, or buffer full)
//   start        request transmission of the buffered frame
//   busy         a frame is in progress
//   frame_done   one-cycle pulse after the last byte's tx_done
//   send_en      one-cycle launch pulse towards the UART transmitter
//   data_byte_tx registered byte presented to the UART transmitter
//   tx_done      one-cycle completion pulse from the UART transmitter
module uart_frame_tx #(
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0]  SOF   = 8'hA5
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_full,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic       send_en,
  output logic [7:0] data_byte_tx,
  input  logic       tx_done
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    SEND_LEN,
    SEND_PAY
`ifdef UART_FRAME_CHKSUM_EN
    ,
    SEND_CHK
`endif
  } state_t;

  // Payload storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] frame_len_q;
  logic [IW-1:0] rd_idx_q;
  logic [IW-1:0] rd_idx_d;
  logic [IW-1:0] rd_idx_inc;

  // FSM: state plus ISSUE (issue_q=1) / WAIT (issue_q=0) phase
  state_t        state_q;
  state_t        state_d;
  logic          issue_q;
  logic          issue_d;

  // Byte launched on entry to the next ISSUE phase
  logic          load_d;
  logic [7:0]    byte_d;
  logic          end_d;

  // Input qualification
  logic          wr_acc;
  logic          start_acc;
  logic [CW-1:0] n_frame;
  logic          pay_last;

`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0]    chk_q;
`endif

  // ------------------------------------------------------------------
  // Output / qualification logic
  // ------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != IDLE);
    send_en   = busy && issue_q;
    wr_full   = busy || (count_q == CW'(DEPTH));
    wr_acc    = wr_en && !wr_full;
    // A write accepted in the same cycle as start is part of the frame.
    n_frame   = count_q + CW'(wr_acc);
    start_acc = (state_q == IDLE) && start && (n_frame != '0);
  end

  assign rd_idx_inc = rd_idx_q + IW'(1);
  assign pay_last   = ({1'b0, rd_idx_q} == (frame_len_q - CW'(1)));

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  // An ISSUE phase always lasts exactly one cycle, so send_en can never be
  // high on two consecutive cycles; tx_done is only looked at in WAIT.
  always_comb begin
    state_d  = state_q;
    issue_d  = 1'b0;
    load_d   = 1'b0;
    byte_d   = '0;
    rd_idx_d = rd_idx_q;
    end_d    = 1'b0;

    if (state_q == IDLE) begin
      if (start_acc) begin
        state_d = SEND_HDR;
        issue_d = 1'b1;
        load_d  = 1'b1;
        byte_d  = SOF;
      end
    end else if (!issue_q && tx_done) begin
      case (state_q)
        SEND_HDR: begin
          state_d = SEND_LEN;
          issue_d = 1'b1;
          load_d  = 1'b1;
          byte_d  = 8'(frame_len_q);
        end
        SEND_LEN: begin
          state_d  = SEND_PAY;
          issue_d  = 1'b1;
          load_d   = 1'b1;
          byte_d   = mem[0];
          rd_idx_d = '0;
        end
        SEND_PAY: begin
          if (!pay_last) begin
            issue_d  = 1'b1;
            load_d   = 1'b1;
            byte_d   = mem[rd_idx_inc];
            rd_idx_d = rd_idx_inc;
          end else begin
`ifdef UART_FRAME_CHKSUM_EN
            state_d = SEND_CHK;
            issue_d = 1'b1;
            load_d  = 1'b1;
            byte_d  = chk_q;
`else
            state_d  = IDLE;
            end_d    = 1'b1;
            rd_idx_d = '0;
`endif
          end
        end
`ifdef UART_FRAME_CHKSUM_EN
        SEND_CHK: begin
          state_d  = IDLE;
          end_d    = 1'b1;
          rd_idx_d = '0;
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_byte_tx <= '0;
      frame_done   <= 1'b0;
      count_q      <= '0;
      frame_len_q  <= '0;
      rd_idx_q     <= '0;
    end else begin
      frame_done <= end_d;
      rd_idx_q   <= rd_idx_d;
      if (load_d) begin
        data_byte_tx <= byte_d;
      end
      if (start_acc) begin
        frame_len_q <= n_frame;
      end
      // Writes are only accepted while idle, so they never race frame end.
      if (end_d) begin
        count_q <= '0;
      end else if (wr_acc) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

`ifdef UART_FRAME_CHKSUM_EN
  // Checksum follows the bytes as they are issued: seeded with the length
  // byte, then folded with each payload byte on its way out.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chk_q <= '0;
    end else if (load_d) begin
      if (state_d == SEND_LEN) begin
        chk_q <= byte_d;
      end else if (state_d == SEND_PAY) begin
        chk_q <= chk_q ^ byte_d;
      end
    end
  end
`endif

  // Buffer contents need no reset: count_q gates what is ever read.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[count_q[IW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
module tb_uart_frame_tx;

  localparam int unsigned DEPTH = 16;
  localparam logic [7:0]  SOF   = 8'hA5;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       resp_done = 1'b0;
  logic       man_done = 1'b0;
  logic       tx_done;
  logic       wr_full;
  logic       busy;
  logic       frame_done;
  logic       send_en;
  logic [7:0] data_byte_tx;

  assign tx_done = resp_done | man_done;

  uart_frame_tx #(.DEPTH(DEPTH), .SOF(SOF)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_full      (wr_full),
    .start        (start),
    .busy         (busy),
    .frame_done   (frame_done),
    .send_en      (send_en),
    .data_byte_tx (data_byte_tx),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int frames_expected = 0;

  logic [7:0] got_q[$];
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];

  int   send_cnt   = 0;
  int   done_cnt   = 0;
  int   consec_cnt = 0;
  logic prev_send  = 1'b0;

  // Monitor: record launched bytes and pulse statistics.
  always @(negedge clk) begin
    if (nrst) begin
      if (send_en) begin
        got_q.push_back(data_byte_tx);
        send_cnt <= send_cnt + 1;
      end
      if (send_en && prev_send) consec_cnt <= consec_cnt + 1;
      if (frame_done) done_cnt <= done_cnt + 1;
      prev_send <= send_en;
    end else begin
      prev_send <= 1'b0;
    end
  end

  // UART transmitter stand-in: tx_done about 10 cycles after each send_en.
  initial begin
    forever begin
      @(negedge clk);
      while (send_en) begin
        repeat (9) @(negedge clk);
        resp_done = 1'b1;
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame straight from the byte-order rule.
  task automatic build_expected();
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(SOF);
    exp_q.push_back(8'(model_q.size()));
    x = 8'(model_q.size());
    foreach (model_q[i]) begin
      exp_q.push_back(model_q[i]);
      x = x ^ model_q[i];
    end
`ifdef UART_FRAME_CHKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (model_q.size() < DEPTH) model_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit with_write,
                           input logic [7:0] wb, input bit spurious);
    int cyc;
    int n;
    if (with_write && model_q.size() < DEPTH) model_q.push_back(wb);
    build_expected();
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    if (with_write) begin
      wr_en   = 1'b1;
      wr_data = wb;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    chk({tag, "_busy_t1"}, 32'(busy), 32'd1);
    chk({tag, "_send_en_t1"}, 32'(send_en), 32'd1);
    chk({tag, "_sof_t1"}, 32'(data_byte_tx), 32'(SOF));
    if (spurious) begin
      repeat (25) @(negedge clk);
      start   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'h77;
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
      chk({tag, "_wr_full_mid"}, 32'(wr_full), 32'd1);
    end
    cyc = 0;
    while (!frame_done && cyc < 1500) begin
      @(negedge clk);
      cyc++;
    end
    frames_expected++;
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_wr_full_end"}, 32'(wr_full), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    model_q.delete();
  endtask

  task automatic empty_start(input string tag);
    int s0;
    int d0;
    repeat (2) @(negedge clk);
    s0 = send_cnt;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    chk({tag, "_no_send"}, 32'(send_cnt), 32'(s0));
    chk({tag, "_no_done"}, 32'(done_cnt), 32'(d0));
  endtask

  initial begin
    int cyc;
    int n;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_send_en", 32'(send_en), 32'd0);
    chk("rst_data", 32'(data_byte_tx), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    chk("rel_wr_full", 32'(wr_full), 32'd0);
    chk("rel_frame_done", 32'(frame_done), 32'd0);

    // Basic three-byte frame
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    run_frame("basic", 1'b0, 8'h00, 1'b0);

    // tx_done while idle changes nothing
    repeat (15) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("idle_txd_busy", 32'(busy), 32'd0);
    chk("idle_txd_send_en", 32'(send_en), 32'd0);
    chk("idle_txd_data", 32'(data_byte_tx), 32'(exp_q[exp_q.size()-1]));
    chk("idle_txd_done", 32'(frame_done), 32'd0);

    // Empty start
    empty_start("empty");

    // Full buffer: 17 writes, last dropped
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(i));
      if (i == 14) chk("full_wr_full_15", 32'(wr_full), 32'd0);
      if (i == 15) chk("full_wr_full_16", 32'(wr_full), 32'd1);
    end
    run_frame("full", 1'b0, 8'h00, 1'b0);

    // Write and start in the same cycle
    run_frame("same", 1'b1, 8'h5A, 1'b0);

    // Writes and start while busy are ignored
    write_byte(8'hC3);
    write_byte(8'h3C);
    run_frame("spur", 1'b0, 8'h00, 1'b1);
    empty_start("after_spur");

    // Reset during the payload phase
    for (int i = 0; i < 5; i++) write_byte(8'($urandom));
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (got_q.size() < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_send_en", 32'(send_en), 32'd0);
    chk("mid_rst_data", 32'(data_byte_tx), 32'd0);
    chk("mid_rst_wr_full", 32'(wr_full), 32'd0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    model_q.delete();
    repeat (15) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt), 32'(frames_expected));
    empty_start("after_rst");

    // Random frames
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) write_byte(8'($urandom));
      run_frame($sformatf("rand%0d", k), 1'b0, 8'h00, 1'b0);
    end

    repeat (15) @(negedge clk);
    chk("total_frame_done", 32'(done_cnt), 32'(frames_expected));
    chk("send_en_consecutive", 32'(consec_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
